// File: rtl/lc3b_pkg.sv
// Shared LC-3b definitions for the operand-fetch stage and the ALU behind it.
// Provides datapath sizing, operate-class opcode constants and the ALUK
// function encoding, which must stay identical to the ALU's own decode.
package lc3b_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NREG   = 8;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b1001;

  typedef enum logic [1:0] {
    AlukAdd  = 2'd0,
    AlukAnd  = 2'd1,
    AlukXor  = 2'd2,
    AlukPass = 2'd3
  } aluk_e;

endpackage

// File: rtl/lc3b_regfile.sv
// Architectural register file: NREG x DATA_W, two asynchronous read ports and
// one synchronous write port. A read of the register being written in the same
// cycle returns the incoming write data, so write-then-read is never stale.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (all registers -> 0)
//   we/waddr/wdata    write port, committed on the rising edge
//   raddr_a/rdata_a   read port A (bypassed)
//   raddr_b/rdata_b   read port B (bypassed)
module lc3b_regfile #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 8,
  parameter int unsigned AddrW  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AddrW-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AddrW-1:0]  raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [AddrW-1:0]  raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata_a = (we && (waddr == raddr_a)) ? wdata : regs_q[raddr_a];
  assign rdata_b = (we && (waddr == raddr_b)) ? wdata : regs_q[raddr_b];

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage in front of the LC-3b ALU. Decodes ADD/AND/XOR(NOT),
// reads SR1/SR2 from the register file, applies the SR2MUX (register or
// sext(imm5)) and holds the result in an output register behind valid/ready.
// A per-register busy scoreboard stalls instructions whose sources still have
// a writeback pending.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   instr/instr_valid/ready     incoming instruction handshake
//   op_a/op_b/op_aluk/op_dr/
//   op_we/op_illegal            held operation presented to the ALU
//   op_valid/op_ready           outgoing operation handshake
//   wb_en/wb_dr/wb_data         writeback port (independent of handshakes)
module alu_operand_stage #(
  parameter int unsigned DATA_W = lc3b_pkg::DATA_W,
  parameter int unsigned NREG   = lc3b_pkg::NREG
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [1:0]        op_aluk,
  output logic [2:0]        op_dr,
  output logic              op_we,
  output logic              op_illegal,
  output logic              op_valid,
  input  logic              op_ready,
  input  logic              wb_en,
  input  logic [2:0]        wb_dr,
  input  logic [DATA_W-1:0] wb_data
);

  import lc3b_pkg::*;

  // Instruction fields
  logic [3:0] opcode;
  logic [2:0] dr, sr1, sr2;
  logic       use_imm;

  assign opcode  = instr[15:12];
  assign dr      = instr[11:9];
  assign sr1     = instr[8:6];
  assign use_imm = instr[5];
  assign sr2     = instr[2:0];

  // Decode
  aluk_e dec_aluk;
  logic  dec_we;
  logic  dec_illegal;

  always_comb begin
    dec_aluk    = AlukPass;
    dec_we      = 1'b1;
    dec_illegal = 1'b0;
    case (opcode)
      OP_ADD:  dec_aluk = AlukAdd;
      OP_AND:  dec_aluk = AlukAnd;
      OP_XOR:  dec_aluk = AlukXor;
      default: begin
        dec_aluk    = AlukPass;
        dec_we      = 1'b0;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Register read (bypassed inside the regfile)
  logic [DATA_W-1:0] sr1_val, sr2_val, imm_sext, src_b;

  lc3b_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .AddrW  (3)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wb_en),
    .waddr   (wb_dr),
    .wdata   (wb_data),
    .raddr_a (sr1),
    .rdata_a (sr1_val),
    .raddr_b (sr2),
    .rdata_b (sr2_val)
  );

  assign imm_sext = {{(DATA_W-5){instr[4]}}, instr[4:0]};
  assign src_b    = use_imm ? imm_sext : sr2_val;

  // Scoreboard hazard. A writeback landing this cycle resolves the hazard
  // because the regfile bypass already delivers its data.
  logic [NREG-1:0] busy_q, busy_d;
  logic            wb_hit_sr1, wb_hit_sr2, hazard;

  assign wb_hit_sr1 = wb_en && (wb_dr == sr1);
  assign wb_hit_sr2 = wb_en && (wb_dr == sr2);
  assign hazard     = !dec_illegal &&
                      ((busy_q[sr1] && !wb_hit_sr1) ||
                       (!use_imm && busy_q[sr2] && !wb_hit_sr2));

  // Output operation register
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  aluk_e             op_aluk_q, op_aluk_d;
  logic [2:0]        op_dr_q, op_dr_d;
  logic              op_we_q, op_we_d;
  logic              op_illegal_q, op_illegal_d;
  logic              op_valid_q, op_valid_d;
  logic              accept;

  assign instr_ready = (!op_valid_q || op_ready) && !hazard;
  assign accept      = instr_valid && instr_ready;

  always_comb begin
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_aluk_d    = op_aluk_q;
    op_dr_d      = op_dr_q;
    op_we_d      = op_we_q;
    op_illegal_d = op_illegal_q;
    op_valid_d   = op_valid_q;
    busy_d       = busy_q;

    if (accept) begin
      op_a_d       = sr1_val;
      op_b_d       = src_b;
      op_aluk_d    = dec_aluk;
      op_dr_d      = dr;
      op_we_d      = dec_we;
      op_illegal_d = dec_illegal;
      op_valid_d   = 1'b1;
    end else if (op_ready) begin
      op_valid_d   = 1'b0;
    end

    // Clear first so a same-index set in the same cycle wins.
    if (wb_en) begin
      busy_d[wb_dr] = 1'b0;
    end
    if (accept && dec_we) begin
      busy_d[dr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_aluk_q    <= AlukPass;
      op_dr_q      <= '0;
      op_we_q      <= 1'b0;
      op_illegal_q <= 1'b0;
      op_valid_q   <= 1'b0;
      busy_q       <= '0;
    end else begin
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_aluk_q    <= op_aluk_d;
      op_dr_q      <= op_dr_d;
      op_we_q      <= op_we_d;
      op_illegal_q <= op_illegal_d;
      op_valid_q   <= op_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign op_aluk    = op_aluk_q;
  assign op_dr      = op_dr_q;
  assign op_we      = op_we_q;
  assign op_illegal = op_illegal_q;
  assign op_valid   = op_valid_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

  logic        clk;
  logic        rst_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [1:0]  op_aluk;
  logic [2:0]  op_dr;
  logic        op_we;
  logic        op_illegal;
  logic        op_valid;
  logic        op_ready;
  logic        wb_en;
  logic [2:0]  wb_dr;
  logic [15:0] wb_data;

  int total;
  int bad;

  alu_operand_stage #(
    .DATA_W (16),
    .NREG   (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_aluk     (op_aluk),
    .op_dr       (op_dr),
    .op_we       (op_we),
    .op_illegal  (op_illegal),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .wb_en       (wb_en),
    .wb_dr       (wb_dr),
    .wb_data     (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic writeback(input logic [2:0] r, input logic [15:0] d);
    wb_en = 1'b1; wb_dr = r; wb_data = d;
    step();
    wb_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr = '0; instr_valid = 1'b0; op_ready = 1'b1;
    wb_en = 1'b0; wb_dr = '0; wb_data = '0;
    #12;
    total++; if (op_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", op_valid); end
    total++; if (op_aluk !== 2'd3) begin bad++; $display("FAIL reset_aluk got=%0d exp=3", op_aluk); end
    total++; if (op_a !== 16'h0 || op_b !== 16'h0) begin bad++; $display("FAIL reset_ab got=%h/%h exp=0000/0000", op_a, op_b); end
    total++; if (op_dr !== 3'd0 || op_we !== 1'b0 || op_illegal !== 1'b0) begin bad++; $display("FAIL reset_ctl got=dr%0d we%b ill%b exp=dr0 we0 ill0", op_dr, op_we, op_illegal); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add_imm();
    instr = 16'h1225; instr_valid = 1'b1; // ADD R1,R0,#5
    #1;
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL add_ready got=%b exp=1", instr_ready); end
    step();
    instr_valid = 1'b0;
    total++; if (op_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", op_valid); end
    total++; if (op_a !== 16'h0000 || op_b !== 16'h0005) begin bad++; $display("FAIL add_ab got=%h/%h exp=0000/0005", op_a, op_b); end
    total++; if (op_aluk !== 2'd0 || op_dr !== 3'd1 || op_we !== 1'b1) begin bad++; $display("FAIL add_ctl got=k%0d dr%0d we%b exp=k0 dr1 we1", op_aluk, op_dr, op_we); end
    step();
    total++; if (op_valid !== 1'b0) begin bad++; $display("FAIL add_drain got=%b exp=0", op_valid); end
  endtask

  task automatic test_hazard_bypass();
    instr = 16'h1441; instr_valid = 1'b1; // ADD R2,R1,R1 while R1 busy
    #1;
    total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL haz_block got=%b exp=0", instr_ready); end
    step();
    total++; if (instr_ready !== 1'b0 || op_valid !== 1'b0) begin bad++; $display("FAIL haz_hold got=rdy%b v%b exp=rdy0 v0", instr_ready, op_valid); end
    wb_en = 1'b1; wb_dr = 3'd1; wb_data = 16'h0005;
    #1;
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL haz_unblock got=%b exp=1", instr_ready); end
    step();
    wb_en = 1'b0; instr_valid = 1'b0;
    total++; if (op_a !== 16'h0005 || op_b !== 16'h0005) begin bad++; $display("FAIL haz_bypass got=%h/%h exp=0005/0005", op_a, op_b); end
    total++; if (op_dr !== 3'd2 || op_valid !== 1'b1) begin bad++; $display("FAIL haz_dr got=dr%0d v%b exp=dr2 v1", op_dr, op_valid); end
  endtask

  task automatic test_back_to_back_sext();
    instr = 16'h56FF; instr_valid = 1'b1; // AND R3,R3,#-1
    #1;
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL sext_ready1 got=%b exp=1", instr_ready); end
    step();
    total++; if (op_b !== 16'hFFFF || op_aluk !== 2'd1 || op_dr !== 3'd3) begin bad++; $display("FAIL sext_and got=b%h k%0d dr%0d exp=bFFFF k1 dr3", op_b, op_aluk, op_dr); end
    instr = 16'h993F; // NOT R4,R4
    #1;
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL sext_ready2 got=%b exp=1", instr_ready); end
    step();
    instr_valid = 1'b0;
    total++; if (op_b !== 16'hFFFF || op_aluk !== 2'd2 || op_dr !== 3'd4 || op_valid !== 1'b1) begin bad++; $display("FAIL sext_not got=b%h k%0d dr%0d v%b exp=bFFFF k2 dr4 v1", op_b, op_aluk, op_dr, op_valid); end
    writeback(3'd2, 16'h00A0);
    writeback(3'd4, 16'h0F0F);
    writeback(3'd7, 16'h00BE);
  endtask

  task automatic test_back_pressure();
    op_ready = 1'b0;
    instr = 16'h1A63; instr_valid = 1'b1; // ADD R5,R1,#3
    step();
    instr = 16'h9C84; // XOR R6,R2,R4
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL bp_ready%0d got=%b exp=0", i, instr_ready); end
      total++; if (op_valid !== 1'b1 || op_a !== 16'h0005 || op_b !== 16'h0003 || op_dr !== 3'd5) begin bad++; $display("FAIL bp_hold%0d got=v%b a%h b%h dr%0d exp=v1 a0005 b0003 dr5", i, op_valid, op_a, op_b, op_dr); end
      step();
    end
    op_ready = 1'b1;
    #1;
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", instr_ready); end
    step();
    instr_valid = 1'b0;
    total++; if (op_a !== 16'h00A0 || op_b !== 16'h0F0F || op_aluk !== 2'd2 || op_dr !== 3'd6) begin bad++; $display("FAIL bp_next got=a%h b%h k%0d dr%0d exp=a00A0 b0F0F k2 dr6", op_a, op_b, op_aluk, op_dr); end
  endtask

  task automatic test_illegal();
    instr = 16'hC1C0; instr_valid = 1'b1; // JMP R7
    step();
    total++; if (op_illegal !== 1'b1 || op_we !== 1'b0 || op_aluk !== 2'd3) begin bad++; $display("FAIL ill_ctl got=ill%b we%b k%0d exp=ill1 we0 k3", op_illegal, op_we, op_aluk); end
    total++; if (op_a !== 16'h00BE) begin bad++; $display("FAIL ill_a got=%h exp=00BE", op_a); end
    instr = 16'hC0C0; // JMP R3, R3 busy: no hazard check on illegal ops
    #1;
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL ill_nohaz got=%b exp=1", instr_ready); end
    step();
    total++; if (op_illegal !== 1'b1 || op_a !== 16'h0000) begin bad++; $display("FAIL ill_r3 got=ill%b a%h exp=ill1 a0000", op_illegal, op_a); end
    instr = 16'h1200; // ADD R1,R0,R0: R0 must not have been marked busy
    #1;
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL ill_nobusy got=%b exp=1", instr_ready); end
    instr_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    step();
    op_ready = 1'b0;
    instr = 16'h1061; instr_valid = 1'b1; // ADD R0,R1,#1
    step();
    instr = 16'h1EE0; // ADD R7,R3,#0, R3 busy
    #1;
    total++; if (op_valid !== 1'b1 || op_b !== 16'h0001 || instr_ready !== 1'b0) begin bad++; $display("FAIL ar_pre got=v%b b%h rdy%b exp=v1 b0001 rdy0", op_valid, op_b, instr_ready); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (op_valid !== 1'b0 || op_aluk !== 2'd3 || op_b !== 16'h0000) begin bad++; $display("FAIL ar_clear got=v%b k%0d b%h exp=v0 k3 b0000", op_valid, op_aluk, op_b); end
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL ar_busy got=%b exp=1", instr_ready); end
    #2 rst_n = 1'b1;
    op_ready = 1'b1;
    instr = 16'h1060; // ADD R0,R1,#0: R1 must read 0 after reset
    step();
    instr_valid = 1'b0;
    total++; if (op_valid !== 1'b1 || op_a !== 16'h0000 || op_dr !== 3'd0) begin bad++; $display("FAIL ar_regs got=v%b a%h dr%0d exp=v1 a0000 dr0", op_valid, op_a, op_dr); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_add_imm();
    test_hazard_bypass();
    test_back_to_back_sext();
    test_back_pressure();
    test_illegal();
    test_async_reset();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
